// File: rtl/cordic_pkg.sv
// cordic_pkg
// Shared types and the elaboration-time arctangent table generator for the
// iterative CORDIC engine.
//   mode_e     : ROTATION (drive z to 0) / VECTORING (drive y to 0)
//   state_e    : engine control states
//   atan_entry : round(atan(2^-index) * 2^(width-1) / pi), binary-scaled angle
package cordic_pkg;

    typedef enum logic {
        ROTATION  = 1'b0,
        VECTORING = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam real Pi = 3.14159265358979323846;

    // Only ever called with constant arguments, so it folds away at elaboration.
    function automatic logic [31:0] atan_entry(input int width, input int index);
        real angle;
        angle = $atan(2.0 ** (-index)) * (2.0 ** (width - 1)) / Pi;
        return 32'($rtoi(angle + 0.5));
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom
// Combinational arctangent table indexed by the iteration counter.
//   index : iteration number (entries at or beyond Iterations read as 0)
//   angle : atan(2^-index) in binary-scaled angle units, Width bits
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int Width      = 16,
    parameter int Iterations = 15
) (
    input  logic [$clog2(Iterations+1)-1:0] index,
    output logic [Width-1:0]                angle
);

    localparam int CntW    = $clog2(Iterations + 1);
    localparam int Entries = 2 ** CntW;

    // Padded to a power of two so every index value selects a defined entry.
    logic [Width-1:0] atan_table [Entries];

    for (genvar g = 0; g < Entries; g++) begin : g_entry
        localparam logic [31:0] Entry = (g < Iterations) ? atan_entry(Width, g) : 32'd0;
        assign atan_table[g] = Entry[Width-1:0];
    end

    assign angle = atan_table[index];

endmodule

// File: rtl/cordic_engine.sv
// cordic_engine
// Iterative (one micro-rotation per clock) CORDIC engine, rotation and
// vectoring modes, gain left uncompensated.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   start_i, mode_i   : start request and mode (0 rotation, 1 vectoring)
//   x0_i, y0_i, z0_i  : signed initial vector and binary-scaled angle
//   xn_o, yn_o, zn_o  : signed results, updated only on entry to DONE
//   busy_o, done_o    : computation in progress / one-cycle result strobe
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | cnt < Iterations: one micro-rotation; cnt == Iterations: publish
// DONE  | results valid for one cycle, new start_i accepted here
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int Width      = 16,
    parameter int Iterations = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    mode_i,
    input  logic signed [Width-1:0] x0_i,
    input  logic signed [Width-1:0] y0_i,
    input  logic signed [Width-1:0] z0_i,
    output logic signed [Width-1:0] xn_o,
    output logic signed [Width-1:0] yn_o,
    output logic signed [Width-1:0] zn_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int CntW = $clog2(Iterations + 1);
    localparam logic signed [Width-1:0] Quarter = {2'b01, {(Width-2){1'b0}}};

    state_e state, state_next;
    mode_e  mode;

    logic [CntW-1:0] cnt;
    logic signed [Width-1:0] x, y, z;
    logic signed [Width-1:0] x_pre, y_pre, z_pre;
    logic signed [Width-1:0] x_shift, y_shift;
    logic signed [Width-1:0] x_step, y_step, z_step;
    logic signed [Width-1:0] angle;
    logic accept, last, dir;

    assign accept = start_i && (state != RUN);
    assign last   = (cnt == CntW'(Iterations));

    cordic_atan_rom #(
        .Width      (Width),
        .Iterations (Iterations)
    ) u_atan_rom (
        .index (cnt),
        .angle (angle)
    );

    // Quadrant pre-correction brings the problem into the +/- pi/2 range
    // where the micro-rotations converge.
    always_comb begin
        x_pre = x0_i;
        y_pre = y0_i;
        z_pre = z0_i;
        if (mode_e'(mode_i) == ROTATION) begin
            if (z0_i >= Quarter) begin
                x_pre = -y0_i;
                y_pre = x0_i;
                z_pre = z0_i - Quarter;
            end else if (z0_i < -Quarter) begin
                x_pre = y0_i;
                y_pre = -x0_i;
                z_pre = z0_i + Quarter;
            end
        end else if (x0_i[Width-1]) begin
            if (!y0_i[Width-1]) begin
                x_pre = y0_i;
                y_pre = -x0_i;
                z_pre = z0_i + Quarter;
            end else begin
                x_pre = -y0_i;
                y_pre = x0_i;
                z_pre = z0_i - Quarter;
            end
        end
    end

    // Single shared micro-rotation stage.
    always_comb begin
        x_shift = x >>> cnt;
        y_shift = y >>> cnt;
        dir     = (mode == ROTATION) ? ~z[Width-1] : y[Width-1];
        if (dir) begin
            x_step = x - y_shift;
            y_step = y + x_shift;
            z_step = z - angle;
        end else begin
            x_step = x + y_shift;
            y_step = y - x_shift;
            z_step = z + angle;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = RUN;
            RUN:     if (last)    state_next = DONE;
            DONE:    state_next = start_i ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state)
            RUN:     busy_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt  <= '0;
            mode <= ROTATION;
            x    <= '0;
            y    <= '0;
            z    <= '0;
            xn_o <= '0;
            yn_o <= '0;
            zn_o <= '0;
        end else if (accept) begin
            cnt  <= '0;
            mode <= mode_e'(mode_i);
            x    <= x_pre;
            y    <= y_pre;
            z    <= z_pre;
        end else if (state == RUN) begin
            if (last) begin
                xn_o <= x;
                yn_o <= y;
                zn_o <= z;
            end else begin
                cnt <= cnt + CntW'(1);
                x   <= x_step;
                y   <= y_step;
                z   <= z_step;
            end
        end
    end

endmodule
